// File: rtl/hid_event_hub_pkg.sv
// Shared definitions for the HID event hub: register indices, field bit positions
// and an address helper for bus masters.
package hid_event_hub_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_idx_e;

  // Byte address layout: [4:3] register index, [7:5] channel.
  localparam int ADDR_REG_LSB = 3;
  localparam int ADDR_CH_LSB  = 5;

  localparam int DATA_EMPTY_BIT = 63;
  localparam int DATA_OVF_BIT   = 62;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_UDF_BIT   = 19;
  localparam int STAT_DROP_LSB  = 32;
  localparam int STAT_CLR_BIT   = 0;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic logic [7:0] reg_addr(input logic [2:0] ch, input reg_idx_e idx);
    return {ch, idx, 3'b000};
  endfunction

endpackage

// File: rtl/hid_event_hub_if.sv
// Register bus shared with the frame store: strobe, byte enables, address and data.
interface hid_event_hub_if #(
  parameter int ADDR_W = 8
);
  logic              hid_en;
  logic [7:0]        hid_we;
  logic [ADDR_W-1:0] hid_addr;
  logic [63:0]       hid_wrdata;
  logic [63:0]       hid_rddata;

  modport master (output hid_en, hid_we, hid_addr, hid_wrdata, input hid_rddata);
  modport slave  (input hid_en, hid_we, hid_addr, hid_wrdata, output hid_rddata);
endinterface

// File: rtl/hid_event_hub_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; head word is presented combinationally.
module hid_event_hub_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Flush overrides both ports; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // NOTE: storage has no reset; pointers and count define which words are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: synchronous reset lives inside the clocked block, so rst_i is not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/hid_event_hub.sv
// Multi-channel HID event buffer: per-channel FIFO, sticky error flags, drop counter,
// flush and a combined level interrupt behind the hid_* register bus.
module hid_event_hub
  import hid_event_hub_pkg::*;
#(
  parameter int         N_CH     = 2,
  parameter int         DW       = 32,
  parameter int         DEPTH    = 16,
  parameter logic [7:0] EDGE_DET = 8'b01,
  parameter int         ADDR_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CH-1:0]    ev_valid_i,
  input  logic [N_CH*DW-1:0] ev_data_i,
  hid_event_hub_if.slave     bus,
  output logic               irq_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic     wr_acc;
  logic     rd_acc;
  logic [2:0] ch_sel;
  reg_idx_e reg_sel;

  assign wr_acc  = bus.hid_en & (|bus.hid_we);
  assign rd_acc  = bus.hid_en & ~(|bus.hid_we);
  assign ch_sel  = bus.hid_addr[ADDR_CH_LSB +: 3];
  assign reg_sel = reg_idx_e'(bus.hid_addr[ADDR_REG_LSB +: 2]);

  logic [DW-1:0]   head  [N_CH];
  logic [CW-1:0]   cnt   [N_CH];
  logic [15:0]     drops [N_CH];
  logic [N_CH-1:0] empty_v;
  logic [N_CH-1:0] full_v;
  logic [N_CH-1:0] ovf_v;
  logic [N_CH-1:0] udf_v;
  logic [N_CH-1:0] en_v;
  logic [N_CH-1:0] irq_en_v;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic          sel;
    logic          pop;
    logic          stat_wr;
    logic          ctrl_wr;
    logic          flush;
    logic          raw;
    logic          push;
    logic          drop;
    logic          valid_q;
    logic          enable;
    logic          irq_en;
    logic          overflow;
    logic          underflow;
    logic [15:0]   drop_cnt;
    logic [DW-1:0] fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign sel     = wr_acc & (ch_sel == 3'(c));
    assign pop     = sel & (reg_sel == REG_DATA);
    assign stat_wr = sel & (reg_sel == REG_STATUS);
    assign ctrl_wr = sel & (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr & bus.hid_wrdata[CTRL_FLUSH_BIT];

    // valid_q follows the strobe even while disabled so re-enabling never fakes an edge.
    assign raw  = EDGE_DET[c] ? (ev_valid_i[c] & ~valid_q) : ev_valid_i[c];
    assign push = enable & raw;
    assign drop = push & ~flush & fifo_full & ~pop;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q   <= 1'b0;
        enable    <= 1'b1;
        irq_en    <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        drop_cnt  <= '0;
      end else begin
        valid_q <= ev_valid_i[c];
        if (ctrl_wr) begin
          enable <= bus.hid_wrdata[CTRL_ENABLE_BIT];
          irq_en <= bus.hid_wrdata[CTRL_IRQ_EN_BIT];
        end
        if (stat_wr && bus.hid_wrdata[STAT_CLR_BIT]) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
          drop_cnt  <= '0;
        end
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 16'd1;
        end
        if (pop && fifo_empty) underflow <= 1'b1;
      end
    end

    hid_event_hub_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (ev_data_i[c*DW +: DW]),
      .rd_data (fifo_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
    );

    assign head[c]     = fifo_data;
    assign cnt[c]      = fifo_count;
    assign drops[c]    = drop_cnt;
    assign empty_v[c]  = fifo_empty;
    assign full_v[c]   = fifo_full;
    assign ovf_v[c]    = overflow;
    assign udf_v[c]    = underflow;
    assign en_v[c]     = enable;
    assign irq_en_v[c] = irq_en;
  end

  logic [63:0] rd_value;

  // NOTE: every bit gets a default first so the read mux cannot infer a latch.
  always_comb begin
    rd_value = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == 3'(c)) begin
        case (reg_sel)
          REG_DATA: begin
            rd_value[DATA_EMPTY_BIT] = empty_v[c];
            rd_value[DATA_OVF_BIT]   = ovf_v[c];
            if (!empty_v[c]) rd_value[DW-1:0] = head[c];
          end
          REG_STATUS: begin
            rd_value[15:0]                 = 16'(cnt[c]);
            rd_value[STAT_EMPTY_BIT]       = empty_v[c];
            rd_value[STAT_FULL_BIT]        = full_v[c];
            rd_value[STAT_OVF_BIT]         = ovf_v[c];
            rd_value[STAT_UDF_BIT]         = udf_v[c];
            rd_value[STAT_DROP_LSB +: 16]  = drops[c];
          end
          REG_CTRL: begin
            rd_value[CTRL_ENABLE_BIT] = en_v[c];
            rd_value[CTRL_IRQ_EN_BIT] = irq_en_v[c];
          end
          default: ;
        endcase
      end
    end
  end

  // Read data captures pre-update state of the access cycle and holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.hid_rddata <= '0;
      irq_o          <= 1'b0;
    end else begin
      if (rd_acc) bus.hid_rddata <= rd_value;
      irq_o <= |(~empty_v & en_v & irq_en_v);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.hid_wrdata, bus.hid_addr};

endmodule

// File: tb/tb_hid_event_hub.sv
// Self-checking bench for hid_event_hub: register reads are scored against a queue of
// expected words; channel 1 contents are tracked by a small FIFO model.
module tb_hid_event_hub;
  import hid_event_hub_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  ev_valid;
  logic [63:0] ev_data;
  logic        irq_o;

  hid_event_hub_if #(.ADDR_W(8)) bus ();

  hid_event_hub #(
    .N_CH     (2),
    .DW       (32),
    .DEPTH    (16),
    .EDGE_DET (8'b01),
    .ADDR_W   (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ev_valid_i (ev_valid),
    .ev_data_i  (ev_data),
    .bus        (bus),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] model1 [$];
  int          drop1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] stat_word(input int count, input bit full, input bit ovf,
                                            input bit udf, input int drop);
    logic [63:0] w;
    w = '0;
    w[15:0]  = 16'(count);
    w[16]    = (count == 0);
    w[17]    = full;
    w[18]    = ovf;
    w[19]    = udf;
    w[47:32] = 16'(drop);
    return w;
  endfunction

  function automatic logic [63:0] data_word(input bit empty, input bit ovf, input logic [31:0] hd);
    logic [63:0] w;
    w = '0;
    w[63] = empty;
    w[62] = ovf;
    if (!empty) w[31:0] = hd;
    return w;
  endfunction

  // All tasks start and end one time unit after a rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input int ch, input reg_idx_e idx, input logic [63:0] exp, input string tag);
    bus.hid_en   = 1'b1;
    bus.hid_we   = 8'h00;
    bus.hid_addr = reg_addr(3'(ch), idx);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    bus.hid_en = 1'b0;
    check(tag_q.pop_front(), bus.hid_rddata, exp_q.pop_front());
  endtask

  task automatic bus_write(input int ch, input reg_idx_e idx, input logic [63:0] wd);
    bus.hid_en     = 1'b1;
    bus.hid_we     = 8'hFF;
    bus.hid_addr   = reg_addr(3'(ch), idx);
    bus.hid_wrdata = wd;
    step();
    bus.hid_en = 1'b0;
    bus.hid_we = 8'h00;
  endtask

  task automatic pulse_ch0(input logic [31:0] d);
    ev_valid[0]  = 1'b1;
    ev_data[31:0] = d;
    step();
    ev_valid[0] = 1'b0;
    step();
  endtask

  task automatic push_ch1(input logic [31:0] d);
    ev_valid[1]    = 1'b1;
    ev_data[63:32] = d;
    if (model1.size() < 16) model1.push_back(d);
    else drop1++;
    step();
    ev_valid[1] = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    ev_valid       = '0;
    ev_data        = '0;
    bus.hid_en     = 1'b0;
    bus.hid_we     = '0;
    bus.hid_addr   = '0;
    bus.hid_wrdata = '0;
    drop1          = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    check("reset_rddata", bus.hid_rddata, 64'h0);
    check("reset_irq", {63'h0, irq_o}, 64'h0);
    bus_read(0, REG_CTRL, 64'h1, "reset_ctrl0");
    bus_read(1, REG_STATUS, stat_word(0, 0, 0, 0, 0), "reset_status1");

    // Edge-detect channel: valid held 5 cycles yields one event.
    ev_valid[0]   = 1'b1;
    ev_data[31:0] = 32'hA5;
    step(5);
    ev_valid[0] = 1'b0;
    step();
    bus_read(0, REG_STATUS, stat_word(1, 0, 0, 0, 0), "edge_status0");
    bus_read(0, REG_DATA, 64'h0000_0000_0000_00A5, "edge_data0");

    // Pop the event, then pop an empty FIFO.
    bus_write(0, REG_DATA, 64'h0);
    bus_write(0, REG_DATA, 64'h0);
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 1, 0), "underflow_status0");
    bus_read(0, REG_DATA, 64'h8000_0000_0000_0000, "underflow_data0");
    bus_write(0, REG_STATUS, 64'h1);
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 0, 0), "clear_status0");

    // Level channel: 16 fills it, 3 more are dropped.
    for (int i = 0; i < 19; i++) begin
      ev_valid[1]    = 1'b1;
      ev_data[63:32] = 32'h100 + 32'(i);
      if (model1.size() < 16) model1.push_back(ev_data[63:32]);
      else drop1++;
      step();
    end
    ev_valid[1] = 1'b0;
    step();
    bus_read(1, REG_STATUS, stat_word(model1.size(), 1, 1, 0, drop1), "overflow_status1");
    check("overflow_drop_model", 64'(drop1), 64'd3);
    bus_read(1, REG_DATA, data_word(0, 1, model1[0]), "overflow_data1");
    bus_write(1, REG_STATUS, 64'h1);
    drop1 = 0;
    bus_read(1, REG_STATUS, stat_word(16, 1, 0, 0, 0), "clear_status1");

    // Push and pop on a full FIFO in the same cycle.
    ev_valid[1]    = 1'b1;
    ev_data[63:32] = 32'h300;
    bus.hid_en     = 1'b1;
    bus.hid_we     = 8'h01;
    bus.hid_addr   = reg_addr(3'd1, REG_DATA);
    void'(model1.pop_front());
    model1.push_back(32'h300);
    step();
    ev_valid[1] = 1'b0;
    bus.hid_en  = 1'b0;
    bus.hid_we  = 8'h00;
    bus_read(1, REG_STATUS, stat_word(16, 1, 0, 0, 0), "pushpop_status1");

    // Drain channel 1, checking each head against the model; last one is the new tail.
    for (int i = 0; i < 16; i++) begin
      bus_read(1, REG_DATA, data_word(0, 0, model1[0]), $sformatf("drain1_%0d", i));
      bus_write(1, REG_DATA, 64'h0);
      void'(model1.pop_front());
    end
    bus_read(1, REG_STATUS, stat_word(0, 0, 0, 0, 0), "drained_status1");

    // Interrupt: asserted two cycles after the push, released after the pop.
    bus_write(0, REG_CTRL, 64'h3);
    check("irq_idle", {63'h0, irq_o}, 64'h0);
    ev_valid[0]   = 1'b1;
    ev_data[31:0] = 32'h11;
    step();
    ev_valid[0] = 1'b0;
    check("irq_one_cycle", {63'h0, irq_o}, 64'h0);
    step();
    check("irq_two_cycles", {63'h0, irq_o}, 64'h1);
    bus_write(0, REG_DATA, 64'h0);
    step();
    check("irq_after_pop", {63'h0, irq_o}, 64'h0);

    // Flush with four queued events.
    for (int i = 0; i < 4; i++) pulse_ch0(32'h20 + 32'(i));
    bus_read(0, REG_STATUS, stat_word(4, 0, 0, 0, 0), "flush_pre_status0");
    bus_write(0, REG_CTRL, 64'h7);
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 0, 0), "flush_status0");
    bus_read(0, REG_CTRL, 64'h3, "flush_ctrl0");

    // Flush wins over a push in the same cycle; the lost event is not counted.
    ev_valid[0]   = 1'b1;
    ev_data[31:0] = 32'h77;
    bus_write(0, REG_CTRL, 64'h7);
    ev_valid[0] = 1'b0;
    step();
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 0, 0), "flush_push_status0");

    // Disabled channel ignores events.
    bus_write(0, REG_CTRL, 64'h0);
    pulse_ch0(32'h55);
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 0, 0), "disabled_status0");
    bus_read(0, REG_CTRL, 64'h0, "disabled_ctrl0");

    // Unmapped channel and reserved register.
    bus_write(5, REG_DATA, 64'h0);
    bus_read(5, REG_STATUS, 64'h0, "unmapped_ch5");
    bus_read(0, REG_RSVD, 64'h0, "reserved_reg");

    // Mid-operation reset with both channels partially filled.
    bus_write(0, REG_CTRL, 64'h3);
    for (int i = 0; i < 3; i++) pulse_ch0(32'h40 + 32'(i));
    for (int i = 0; i < 8; i++) push_ch1(32'h500 + 32'(i));
    step();
    bus_read(1, REG_STATUS, stat_word(8, 0, 0, 0, 0), "half_status1");
    check("half_irq", {63'h0, irq_o}, 64'h1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_rddata", bus.hid_rddata, 64'h0);
    check("rst_irq", {63'h0, irq_o}, 64'h0);
    bus_read(0, REG_STATUS, stat_word(0, 0, 0, 0, 0), "rst_status0");
    bus_read(1, REG_STATUS, stat_word(0, 0, 0, 0, 0), "rst_status1");
    bus_read(0, REG_CTRL, 64'h1, "rst_ctrl0");
    bus_read(1, REG_CTRL, 64'h1, "rst_ctrl1");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
